// File: rtl/riscv_ula.sv
// Integer ALU for the single-cycle datapath: add/sub/and/or/xor/slt/sltu.
// Ports: SrcA/SrcB/ULAControl in; ULAResult/Zero/Carry/Overflow comb; Flags reg.
module riscv_ula #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ULAControl,
  input  logic             FlagsEn,
  output logic [WIDTH-1:0] ULAResult,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow,
  output logic [3:0]       Flags
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;

  logic             use_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             sum_c;
  logic             sum_v;
  logic             lt_s;
  logic             lt_u;

  // ADD, SUB, SLT and SLTU share one adder; subtraction is A + ~B + 1.
  assign use_sub = (ULAControl == OP_SUB) ||
                   (ULAControl == OP_SLT) ||
                   (ULAControl == OP_SLTU);
  assign b_eff = use_sub ? ~SrcB : SrcB;
  assign sum   = {1'b0, SrcA} + {1'b0, b_eff} +
                 {{WIDTH{1'b0}}, use_sub};
  assign sum_c = sum[WIDTH];

  // Overflow when both adder inputs agree in sign but the result differs.
  assign sum_v = (SrcA[WIDTH-1] == b_eff[WIDTH-1]) &&
                 (sum[WIDTH-1] != SrcA[WIDTH-1]);

  // Signed less-than must correct the sign by overflow (e.g. 0x80 vs 0x7F);
  // unsigned less-than is simply a borrow.
  assign lt_s = sum[WIDTH-1] ^ sum_v;
  assign lt_u = ~sum_c;

  always_comb begin
    ULAResult = '0;
    Carry     = 1'b0;
    Overflow  = 1'b0;
    case (ULAControl)
      OP_ADD: begin
        ULAResult = sum[WIDTH-1:0];
        Carry     = sum_c;
        Overflow  = sum_v;
      end
      OP_SUB: begin
        ULAResult = sum[WIDTH-1:0];
        Carry     = sum_c;
        Overflow  = sum_v;
      end
      OP_AND: ULAResult = SrcA & SrcB;
      OP_OR:  ULAResult = SrcA | SrcB;
      OP_XOR: ULAResult = SrcA ^ SrcB;
      OP_SLT: begin
        ULAResult = {{(WIDTH-1){1'b0}}, lt_s};
        Carry     = sum_c;
      end
      OP_SLTU: begin
        ULAResult = {{(WIDTH-1){1'b0}}, lt_u};
        Carry     = sum_c;
      end
      default: begin
        ULAResult = '0;
        Carry     = 1'b0;
        Overflow  = 1'b0;
      end
    endcase
  end

  assign Zero = ~|ULAResult;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Flags <= 4'b0000;
    end else if (FlagsEn) begin
      Flags <= {ULAResult[WIDTH-1], Zero, Carry, Overflow};
    end
  end

endmodule

// File: tb/tb_riscv_ula.sv
// Directed self-checking bench for riscv_ula (WIDTH = 8).
// Checks comb result/zero/carry/overflow and the registered flag word.
module tb_riscv_ula;

  logic       clk;
  logic       rst_n;
  logic [7:0] SrcA;
  logic [7:0] SrcB;
  logic [2:0] ULAControl;
  logic       FlagsEn;
  logic [7:0] ULAResult;
  logic       Zero;
  logic       Carry;
  logic       Overflow;
  logic [3:0] Flags;

  int n_run;
  int n_fail;

  riscv_ula #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ULAControl (ULAControl),
    .FlagsEn    (FlagsEn),
    .ULAResult  (ULAResult),
    .Zero       (Zero),
    .Carry      (Carry),
    .Overflow   (Overflow),
    .Flags      (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one op and check all four combinational outputs.
  task automatic op(input string tag,
                    input logic [7:0] a,
                    input logic [7:0] b,
                    input logic [2:0] c,
                    input logic [7:0] er,
                    input logic ez,
                    input logic ec,
                    input logic ev);
    SrcA = a;
    SrcB = b;
    ULAControl = c;
    #1;
    chk({tag, ".res"}, 32'(ULAResult), 32'(er));
    chk({tag, ".z"},   32'(Zero),      32'(ez));
    chk({tag, ".c"},   32'(Carry),     32'(ec));
    chk({tag, ".v"},   32'(Overflow),  32'(ev));
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    rst_n = 1'b0;
    FlagsEn = 1'b0;
    SrcA = 8'h00;
    SrcB = 8'h00;
    ULAControl = 3'b000;
    #1;
    chk("rst_flags", 32'(Flags), 32'h0);

    // A=06 B=03
    op("t1_add",  8'h06, 8'h03, 3'b000, 8'h09, 0, 0, 0);
    op("t1_sub",  8'h06, 8'h03, 3'b001, 8'h03, 0, 1, 0);
    op("t1_and",  8'h06, 8'h03, 3'b010, 8'h02, 0, 0, 0);
    op("t1_or",   8'h06, 8'h03, 3'b011, 8'h07, 0, 0, 0);
    op("t1_xor",  8'h06, 8'h03, 3'b100, 8'h05, 0, 0, 0);
    op("t1_slt",  8'h06, 8'h03, 3'b101, 8'h00, 1, 1, 0);
    op("t1_sltu", 8'h06, 8'h03, 3'b110, 8'h00, 1, 1, 0);
    // A=06 B=07
    op("t2_add",  8'h06, 8'h07, 3'b000, 8'h0D, 0, 0, 0);
    op("t2_sub",  8'h06, 8'h07, 3'b001, 8'hFF, 0, 0, 0);
    op("t2_and",  8'h06, 8'h07, 3'b010, 8'h06, 0, 0, 0);
    op("t2_or",   8'h06, 8'h07, 3'b011, 8'h07, 0, 0, 0);
    op("t2_xor",  8'h06, 8'h07, 3'b100, 8'h01, 0, 0, 0);
    op("t2_slt",  8'h06, 8'h07, 3'b101, 8'h01, 0, 0, 0);
    op("t2_sltu", 8'h06, 8'h07, 3'b110, 8'h01, 0, 0, 0);
    // Signed edge A=80 B=7F
    op("t3_slt",  8'h80, 8'h7F, 3'b101, 8'h01, 0, 1, 0);
    op("t3_sltu", 8'h80, 8'h7F, 3'b110, 8'h00, 1, 1, 0);
    op("t3_sub",  8'h80, 8'h7F, 3'b001, 8'h01, 0, 1, 1);
    op("t3_add",  8'h80, 8'h7F, 3'b000, 8'hFF, 0, 0, 0);
    op("t3_slt_r",8'h7F, 8'h80, 3'b101, 8'h00, 1, 0, 0);
    // Wrap and reserved
    op("t4_wrap", 8'hFF, 8'h01, 3'b000, 8'h00, 1, 1, 0);
    op("t4_sub80",8'h80, 8'h01, 3'b001, 8'h7F, 0, 1, 1);
    op("t4_addv", 8'h7F, 8'h01, 3'b000, 8'h80, 0, 0, 1);
    op("t4_rsv",  8'h5A, 8'hC3, 3'b111, 8'h00, 1, 0, 0);
    op("t4_rsv2", 8'hFF, 8'hFF, 3'b111, 8'h00, 1, 0, 0);

    // Flags still held in reset despite clock edges
    @(posedge clk);
    #1;
    chk("rst_hold", 32'(Flags), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    SrcA = 8'hFF;
    SrcB = 8'h01;
    ULAControl = 3'b000;
    FlagsEn = 1'b1;
    @(posedge clk);
    #1;
    chk("flg_wrap", 32'(Flags), 32'h6);

    @(negedge clk);
    FlagsEn = 1'b0;
    SrcA = 8'h06;
    SrcB = 8'h07;
    ULAControl = 3'b001;
    @(posedge clk);
    #1;
    chk("flg_hold", 32'(Flags), 32'h6);

    @(negedge clk);
    FlagsEn = 1'b1;
    @(posedge clk);
    #1;
    chk("flg_sub", 32'(Flags), 32'h8);

    // Async reset between edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_flg", 32'(Flags), 32'h0);
    chk("arst_res", 32'(ULAResult), 32'hFF);
    chk("arst_c",   32'(Carry), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    FlagsEn = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_noen", 32'(Flags), 32'h0);

    @(negedge clk);
    FlagsEn = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_cap", 32'(Flags), 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
